// File: rtl/bist_march_gen.sv
// bist_march_gen: March C- SRAM BIST controller with read-aligned expected data and fail counting.
// Define BIST_FAIL_LOG_EN to add the first-mismatch log (fail_addr/fail_elem/fail_dir, uses gt/lt).
module bist_march_gen #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] data_t,
    output logic              cmp_valid,
    input  logic              eq,
`ifdef BIST_FAIL_LOG_EN
    input  logic              gt,
    input  logic              lt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [1:0]        fail_dir,
`endif
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [CNT_W-1:0]  fail_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] elem;
    logic [ADDR_W-1:0] acnt;
    logic phase;
    logic [1:0] dcnt;
    logic [RD_LAT-1:0] pv;
    logic [RD_LAT-1:0][DATA_W-1:0] pd;
`ifdef BIST_FAIL_LOG_EN
    logic [RD_LAT-1:0][ADDR_W-1:0] pa;
    logic [RD_LAT-1:0][2:0] pe;
`endif
    logic go, two_op, rd, rd_one, wr_one, last_op;
    assign go      = start && (state == IDLE || state == DONE);
    assign two_op  = elem != 3'd0 && elem != 3'd5;
    assign rd      = elem != 3'd0 && !phase;
    assign rd_one  = elem == 3'd2 || elem == 3'd4;
    assign wr_one  = elem == 3'd1 || elem == 3'd3;
    assign last_op = elem == 3'd5 && acnt == '1;
    // next state and op decode; down elements just invert the up-counting address
    always_comb begin
        state_nx  = go ? RUN
                  : (state == RUN && last_op) ? DRAIN
                  : (state == DRAIN && dcnt == 2'(RD_LAT-1)) ? DONE : state;
        ram_cs    = state == RUN;
        ram_we    = state == RUN && !rd;
        ram_addr  = state != RUN ? '0 : elem >= 3'd3 ? ~acnt : acnt;
        ram_wdata = (state != RUN || rd) ? '0 : {DATA_W{wr_one}};
        cmp_valid = pv[RD_LAT-1];
        data_t    = cmp_valid ? pd[RD_LAT-1] : '0;
        busy      = state == RUN || state == DRAIN;
        done      = state == DONE;
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // march sequencing: phase within element, address within element, element index
    always_ff @(posedge clk) begin
        if (rst || go) begin
            elem  <= '0;
            acnt  <= '0;
            phase <= 1'b0;
            dcnt  <= '0;
        end else if (state == RUN) begin
            if (two_op && !phase) phase <= 1'b1;
            else begin
                phase <= 1'b0;
                acnt  <= acnt + 1'b1;
                if (acnt == '1 && elem != 3'd5) elem <= elem + 3'd1;
            end
        end else if (state == DRAIN) dcnt <= dcnt + 2'd1;
    end
    // read-valid pipe, flushed on reset so an aborted run leaves no stale compares
    always_ff @(posedge clk) begin
        if (rst) pv <= '0;
        else pv <= RD_LAT'({pv, state == RUN && rd});
    end
    // expected-data pipe travelling alongside the valid bit
    always_ff @(posedge clk) begin
        pd <= (RD_LAT*DATA_W)'({pd, {DATA_W{rd_one}}});
`ifdef BIST_FAIL_LOG_EN
        pa <= (RD_LAT*ADDR_W)'({pa, ram_addr});
        pe <= (RD_LAT*3)'({pe, elem});
`endif
    end
    // sticky fail flag and saturating mismatch counter
    always_ff @(posedge clk) begin
        if (rst || go) begin
            fail       <= 1'b0;
            fail_count <= '0;
        end else if (cmp_valid && !eq) begin
            fail <= 1'b1;
            if (fail_count != '1) fail_count <= fail_count + 1'b1;
        end
    end
`ifdef BIST_FAIL_LOG_EN
    // first-mismatch capture; fail still low means this is the first one
    always_ff @(posedge clk) begin
        if (rst || go) begin
            fail_addr <= '0;
            fail_elem <= '0;
            fail_dir  <= '0;
        end else if (cmp_valid && !eq && !fail) begin
            fail_addr <= pa[RD_LAT-1];
            fail_elem <= pe[RD_LAT-1];
            fail_dir  <= {gt, lt};
        end
    end
`endif
endmodule

// File: tb/tb_bist_march_gen.sv
// tb_bist_march_gen: bench for bist_march_gen with a faultable SRAM and an op-list reference model.
module tb_bist_march_gen;
    localparam int NOPS = 160;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0;
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0, nrd = 0;

    logic a_start, a_cs, a_we, a_cv, a_eq, a_busy, a_done, a_fail;
    logic [3:0] a_addr;
    logic [7:0] a_wd, a_dt, a_cnt;
    logic b_start, b_cs, b_we, b_cv, b_eq, b_busy, b_done, b_fail;
    logic [3:0] b_addr, b_cnt;
    logic [7:0] b_wd, b_dt;
    assign a_start = start && !sel;
    assign b_start = start && sel;

    logic [7:0] mem_a [16], mem_b [16], s0 [16], s1 [16], xr [16];
    logic [7:0] rq_a;
    logic [2:0][7:0] rq_b;

    function automatic logic [7:0] rd_val(input logic [7:0] v, input logic [3:0] a);
        return ((v & ~s0[a]) | s1[a]) ^ xr[a];
    endfunction

    always @(posedge clk) begin
        if (a_cs && a_we) mem_a[a_addr] <= a_wd;
        rq_a <= rd_val(mem_a[a_addr], a_addr);
    end
    always @(posedge clk) begin
        if (b_cs && b_we) mem_b[b_addr] <= b_wd;
        rq_b <= {rq_b[1:0], rd_val(mem_b[b_addr], b_addr)};
    end
    assign a_eq = rq_a == a_dt;
    assign b_eq = rq_b[2] == b_dt;

`ifdef BIST_FAIL_LOG_EN
    logic a_gt, a_lt, b_gt, b_lt;
    logic [3:0] a_fa, b_fa, o_fa;
    logic [2:0] a_fe, b_fe, o_fe;
    logic [1:0] a_fd, b_fd, o_fd;
    assign a_gt = rq_a > a_dt;
    assign a_lt = rq_a < a_dt;
    assign b_gt = rq_b[2] > b_dt;
    assign b_lt = rq_b[2] < b_dt;
    assign o_fa = sel ? b_fa : a_fa;
    assign o_fe = sel ? b_fe : a_fe;
    assign o_fd = sel ? b_fd : a_fd;
`endif

    bist_march_gen #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .ram_cs(a_cs), .ram_we(a_we), .ram_addr(a_addr),
        .ram_wdata(a_wd), .data_t(a_dt), .cmp_valid(a_cv), .eq(a_eq),
`ifdef BIST_FAIL_LOG_EN
        .gt(a_gt), .lt(a_lt), .fail_addr(a_fa), .fail_elem(a_fe), .fail_dir(a_fd),
`endif
        .busy(a_busy), .done(a_done), .fail(a_fail), .fail_count(a_cnt));

    bist_march_gen #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .ram_cs(b_cs), .ram_we(b_we), .ram_addr(b_addr),
        .ram_wdata(b_wd), .data_t(b_dt), .cmp_valid(b_cv), .eq(b_eq),
`ifdef BIST_FAIL_LOG_EN
        .gt(b_gt), .lt(b_lt), .fail_addr(b_fa), .fail_elem(b_fe), .fail_dir(b_fd),
`endif
        .busy(b_busy), .done(b_done), .fail(b_fail), .fail_count(b_cnt));

    logic o_cs, o_we, o_cv, o_busy, o_done, o_fail;
    logic [3:0] o_addr;
    logic [7:0] o_wd, o_dt, o_cnt;
    assign o_cs   = sel ? b_cs : a_cs;
    assign o_we   = sel ? b_we : a_we;
    assign o_cv   = sel ? b_cv : a_cv;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_done = sel ? b_done : a_done;
    assign o_fail = sel ? b_fail : a_fail;
    assign o_addr = sel ? b_addr : a_addr;
    assign o_wd   = sel ? b_wd : a_wd;
    assign o_dt   = sel ? b_dt : a_dt;
    assign o_cnt  = sel ? {4'd0, b_cnt} : a_cnt;

    logic       op_rd [NOPS];
    logic [3:0] op_a [NOPS];
    logic [7:0] op_d [NOPS];
    logic [2:0] op_e [NOPS];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // March C- as a flat list of operations built from the element table
    task automatic build();
        int nops [6] = '{1, 2, 2, 2, 2, 1};
        int kind [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};
        int n = 0;
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < 16; i++)
                for (int k = 0; k < nops[e]; k++) begin
                    op_rd[n] = kind[e][k] >= 2;
                    op_a[n]  = 4'(e >= 3 ? 15 - i : i);
                    op_d[n]  = kind[e][k][0] ? 8'hFF : 8'h00;
                    op_e[n]  = 3'(e);
                    nrd += kind[e][k] >= 2 ? 1 : 0;
                    n++;
                end
    endtask

    // replay the op list on an ideal array seen through the fault masks
    task automatic model(output int cnt, output int fa, output int fe, output int fd);
        logic [7:0] m [16];
        logic [7:0] got;
        cnt = 0; fa = 0; fe = 0; fd = 0;
        for (int i = 0; i < NOPS; i++)
            if (!op_rd[i]) m[op_a[i]] = op_d[i];
            else begin
                got = rd_val(m[op_a[i]], op_a[i]);
                if (got != op_d[i]) begin
                    if (cnt == 0) begin
                        fa = op_a[i]; fe = op_e[i]; fd = {30'd0, got > op_d[i], got < op_d[i]};
                    end
                    cnt++;
                end
            end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 16; i++) begin
            s0[i] = 8'h00; s1[i] = 8'h00; xr[i] = 8'h00;
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, " cs"}, o_cs, 0);
        chk({t, " we"}, o_we, 0);
        chk({t, " addr"}, o_addr, 0);
        chk({t, " wdata"}, o_wd, 0);
        chk({t, " data_t"}, o_dt, 0);
        chk({t, " cmp_valid"}, o_cv, 0);
        chk({t, " busy"}, o_busy, 0);
        chk({t, " done"}, o_done, 0);
        chk({t, " fail"}, o_fail, 0);
        chk({t, " fail_count"}, o_cnt, 0);
`ifdef BIST_FAIL_LOG_EN
        chk({t, " fail_addr"}, o_fa, 0);
        chk({t, " fail_elem"}, o_fe, 0);
        chk({t, " fail_dir"}, o_fd, 0);
`endif
    endtask

    task automatic run(input bit s, input int lat, input int cmax, input int xs, input int abort_at);
        int cnt, fa, fe, fd, pulses, k;
        logic cv;
        sel = s;
        model(cnt, fa, fe, fd);
        repeat ($urandom_range(0, 3)) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int c = 1; c <= NOPS + lat + 1; c++) begin
            chk($sformatf("c%0d cs", c), o_cs, c <= NOPS);
            if (c <= NOPS) begin
                chk($sformatf("c%0d we", c), o_we, !op_rd[c-1]);
                chk($sformatf("c%0d addr", c), o_addr, op_a[c-1]);
                chk($sformatf("c%0d wdata", c), o_wd, op_rd[c-1] ? 8'h00 : op_d[c-1]);
            end else chk($sformatf("c%0d we", c), o_we, 0);
            k  = c - 1 - lat;
            cv = (k >= 0 && k < NOPS) ? op_rd[k] : 1'b0;
            chk($sformatf("c%0d cmp_valid", c), o_cv, cv);
            chk($sformatf("c%0d data_t", c), o_dt, cv ? op_d[k] : 8'h00);
            chk($sformatf("c%0d busy", c), o_busy, c <= NOPS + lat);
            chk($sformatf("c%0d done", c), o_done, c == NOPS + lat + 1);
            pulses += o_cv ? 1 : 0;
            if (c == abort_at) begin
                rst = 1'b1;
                tick();
                chk_zero("abort");
                rst = 1'b0;
                return;
            end
            start = c == xs;
            tick();
        end
        start = 1'b0;
        chk("cmp_pulses", pulses, nrd);
        chk("done_hold", o_done, 1);
        chk("fail", o_fail, cnt > 0);
        chk("fail_count", o_cnt, cnt > cmax ? cmax : cnt);
`ifdef BIST_FAIL_LOG_EN
        chk("fail_addr", o_fa, fa);
        chk("fail_elem", o_fe, fe);
        chk("fail_dir", o_fd, fd);
`endif
    endtask

    initial begin
        int a1, a2;
        build();
        clear_faults();
        rst = 1'b1;
        repeat (3) tick();
        sel = 1'b0;
        chk_zero("reset_a");
        sel = 1'b1;
        chk_zero("reset_b");
        rst = 1'b0;
        tick();
        // good RAM with a stray start mid-run
        run(0, 1, 255, $urandom_range(2, 150), 0);
        // stuck-at-0 bit 0 at address 5
        s0[5] = 8'h01;
        run(0, 1, 255, 0, 0);
        clear_faults();
        // random stuck bits at random addresses
        a1 = $urandom_range(0, 15);
        a2 = $urandom_range(0, 15);
        s0[a1] = 8'h01 << $urandom_range(0, 7);
        s1[a2] = 8'h01 << $urandom_range(0, 7);
        run(0, 1, 255, 0, 0);
        clear_faults();
        // restart from DONE must clear the previous failure
        run(0, 1, 255, 0, 0);
        // reset mid-run, then a clean run from IDLE
        run(0, 1, 255, 0, 50);
        run(0, 1, 255, 0, 0);
        // deeper read latency
        run(1, 3, 15, $urandom_range(2, 150), 0);
        // every read wrong: 4-bit counter saturates
        for (int i = 0; i < 16; i++) xr[i] = 8'hFF;
        run(1, 3, 15, 0, 0);
        clear_faults();
        s1[$urandom_range(0, 15)] = 8'h80;
        run(1, 3, 15, 0, 0);
        clear_faults();
        run(1, 3, 15, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
